i2c_txn_arbiter: RTL

Two-port arbiter and transaction sequencer in front of the I2C controller. Each requester issues a complete single-byte register write or register read. The block grants the bus round-robin and drives the controller's start/stop/rwbit/txBuffer handshake byte by byte. It returns read data and the NACK status to the granted requester.

---
 rtl/i2c_txn_arbiter_if.sv | 37 +++
 rtl/i2c_txn_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - requester and I2C controller signal bundle of the transaction arbiter
interface i2c_txn_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_rw;
    logic [13:0] req_addr;
    logic [15:0] req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_id;
    logic [7:0]  rsp_rdata;
    logic        rsp_nack;
    logic        i2c_start;
    logic        i2c_stop;
    logic        i2c_rwbit;
    logic [6:0]  i2c_periphAddr;
    logic [7:0]  i2c_txBuffer;
    logic [7:0]  i2c_rxBuffer;
    logic        i2c_busy;
    logic        i2c_loading;
    logic        i2c_starting;
    logic        i2c_nack;

    modport slave (
        input  req_valid, req_rw, req_addr, req_reg, req_wdata,
        input  i2c_rxBuffer, i2c_busy, i2c_loading, i2c_starting, i2c_nack,
        output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_nack,
        output i2c_start, i2c_stop, i2c_rwbit, i2c_periphAddr, i2c_txBuffer
    );

    modport master (
        output req_valid, req_rw, req_addr, req_reg, req_wdata,
        output i2c_rxBuffer, i2c_busy, i2c_loading, i2c_starting, i2c_nack,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_nack,
        input  i2c_start, i2c_stop, i2c_rwbit, i2c_periphAddr, i2c_txBuffer
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - two-port round-robin register write/read sequencer for the I2C controller
// Define I2C_SEQ_TIMEOUT_EN to abort any transaction stalled in one state for TIMEOUT_CYCLES.
module i2c_txn_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input logic              clk,
    input logic              rst_n,
    i2c_txn_arbiter_if.slave bus
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_START,
        ST_W_REG,
        ST_W_DATA,
        ST_WAIT_IDLE,
        ST_R_START,
        ST_R_DATA,
        ST_ABORT,
        ST_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic        rd_done_q, rd_done_d;
    logic [1:0]  ready_q, ready_d;

    logic        grant;
    logic        active;
    logic        timeout;

    // Contention goes to the port not served last; a lone requester always wins.
    always_comb begin
        if (bus.req_valid == 2'b11) begin
            grant = ~last_q;
        end else begin
            grant = bus.req_valid[1];
        end
    end

    assign active = (state_q == ST_W_START) || (state_q == ST_W_REG) ||
                    (state_q == ST_W_DATA)  || (state_q == ST_WAIT_IDLE) ||
                    (state_q == ST_R_START) || (state_q == ST_R_DATA);

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (state_q != ST_IDLE) && (state_q != ST_RESP) &&
                     (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        nack_d    = nack_q;
        rd_done_d = rd_done_q;
        ready_d   = 2'b00;

        bus.req_ready      = ready_q;
        bus.rsp_valid      = 1'b0;
        bus.rsp_id         = 1'b0;
        bus.rsp_rdata      = 8'h00;
        bus.rsp_nack       = 1'b0;
        bus.i2c_start      = 1'b0;
        bus.i2c_stop       = 1'b0;
        bus.i2c_rwbit      = 1'b0;
        bus.i2c_txBuffer   = 8'h00;
        bus.i2c_periphAddr = (state_q == ST_IDLE) ? 7'd0 : addr_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    ready_d   = grant ? 2'b10 : 2'b01;
                    last_d    = grant;
                    id_d      = grant;
                    rw_d      = grant ? bus.req_rw[1]       : bus.req_rw[0];
                    addr_d    = grant ? bus.req_addr[13:7]  : bus.req_addr[6:0];
                    reg_d     = grant ? bus.req_reg[15:8]   : bus.req_reg[7:0];
                    wdata_d   = grant ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
                    rdata_d   = 8'h00;
                    nack_d    = 1'b0;
                    rd_done_d = 1'b0;
                    state_d   = ST_W_START;
                end
            end
            // A read sends only the register byte in its first phase, so stop rides with it.
            ST_W_START: begin
                bus.i2c_start    = 1'b1;
                bus.i2c_txBuffer = reg_q;
                bus.i2c_stop     = rw_q;
                if (bus.i2c_starting) begin
                    state_d = ST_W_REG;
                end
            end
            ST_W_REG: begin
                bus.i2c_txBuffer = reg_q;
                bus.i2c_stop     = rw_q;
                if (bus.i2c_loading) begin
                    state_d = rw_q ? ST_WAIT_IDLE : ST_W_DATA;
                end
            end
            ST_W_DATA: begin
                bus.i2c_txBuffer = wdata_q;
                bus.i2c_stop     = 1'b1;
                if (bus.i2c_loading) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                bus.i2c_stop = 1'b1;
                if (!bus.i2c_busy) begin
                    state_d = (rw_q && !rd_done_q) ? ST_R_START : ST_RESP;
                end
            end
            ST_R_START: begin
                bus.i2c_start = 1'b1;
                bus.i2c_rwbit = 1'b1;
                bus.i2c_stop  = 1'b1;
                if (bus.i2c_starting) begin
                    state_d = ST_R_DATA;
                end
            end
            ST_R_DATA: begin
                bus.i2c_rwbit = 1'b1;
                bus.i2c_stop  = 1'b1;
                if (bus.i2c_loading) begin
                    rdata_d   = bus.i2c_rxBuffer;
                    rd_done_d = 1'b1;
                    state_d   = ST_WAIT_IDLE;
                end
            end
            ST_ABORT: begin
                bus.i2c_stop = 1'b1;
                if (!bus.i2c_busy) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_id    = id_q;
                bus.rsp_rdata = rdata_q;
                bus.rsp_nack  = nack_q;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // NACK overrides any byte the controller reports in the same cycle.
        if (active && bus.i2c_nack) begin
            bus.i2c_start = 1'b0;
            bus.i2c_stop  = 1'b1;
            nack_d        = 1'b1;
            rdata_d       = 8'h00;
            state_d       = ST_ABORT;
        end

        // The watchdog does not wait for the bus to go idle.
        if (timeout) begin
            bus.i2c_start = 1'b0;
            bus.i2c_stop  = 1'b1;
            nack_d        = 1'b1;
            rdata_d       = 8'h00;
            state_d       = ST_RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= 7'd0;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            nack_q    <= 1'b0;
            rd_done_q <= 1'b0;
            ready_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            nack_q    <= nack_d;
            rd_done_q <= rd_done_d;
            ready_q   <= ready_d;
        end
    end

endmodule
